// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the pipeline forwarding/hazard logic.
//   FWD_*          : ALU operand-select encodings driven to the EX-stage muxes
//   stage_track_t  : what the hazard unit remembers about the instruction
//                    sitting in a pipeline stage (destination, writes, is load)
//   STAGE_BUBBLE   : value loaded into a stage when it holds no instruction
// ---------------------------------------------------------------------------
package pipe_pkg;

  // Register-specifier width baked into stage_track_t. Any instance that
  // overrides REG_ADDR_W must use this same value.
  localparam int PIPE_REG_ADDR_W = 5;

  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_EXMEM   = 2'b10;
  localparam logic [1:0] FWD_MEMWB   = 2'b01;

  typedef struct packed {
    logic [PIPE_REG_ADDR_W-1:0] rd;
    logic                       wr;
    logic                       ld;
  } stage_track_t;

  localparam stage_track_t STAGE_BUBBLE = '{rd: '0, wr: 1'b0, ld: 1'b0};

endpackage

// File: rtl/fwd_select.sv
// ---------------------------------------------------------------------------
// fwd_select
// Priority compare for one source operand. Picks the youngest in-flight
// producer of the source register: EX stage first, then MEM stage, otherwise
// the register file. Register 0 is hard-wired zero and is never forwarded.
// Ports:
//   en      in  1        operand is actually read (0 forces register file)
//   src     in  ADDR_W   source register specifier in ID
//   ex_rd   in  ADDR_W   destination of the instruction now in EX
//   ex_wr   in  1        EX instruction writes its destination
//   mem_rd  in  ADDR_W   destination of the instruction now in MEM
//   mem_wr  in  1        MEM instruction writes its destination
//   fwd     out 2        operand select (FWD_* encoding)
// ---------------------------------------------------------------------------
import pipe_pkg::*;

module fwd_select #(
  parameter int ADDR_W = 5
) (
  input  logic              en,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] ex_rd,
  input  logic              ex_wr,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic              mem_wr,
  output logic [1:0]        fwd
);

  always_comb begin
    fwd = FWD_REGFILE;
    // Checking src!=0 is equivalent to checking rd!=0 once the two are equal.
    if (en && (src != '0)) begin
      if (ex_wr && (ex_rd == src)) begin
        fwd = FWD_EXMEM;
      end else if (mem_wr && (mem_rd == src)) begin
        fwd = FWD_MEMWB;
      end
    end
  end

endmodule

// File: rtl/forward_hazard_unit.sv
// ---------------------------------------------------------------------------
// forward_hazard_unit
// Tracks destination registers through EX, MEM and WB, decides in ID where
// each ALU source operand of the ID instruction will come from, and registers
// that decision so ForwardA/ForwardB line up with the instruction once it is
// in EX. Detects load-use hazards (one-cycle Stall), inserts EX bubbles on
// stall/flush/invalid, and keeps a saturating count of stall cycles.
// Ports:
//   Clk, Reset_n               clock (rising edge), synchronous active-low reset
//   ID_Valid, ID_Rs, ID_Rt,    decoded ID instruction: sources, whether Rt
//   ID_UsesRt, ID_Rd,          is read, destination, writes-Rd, is-load
//   ID_RegWrite, ID_MemRead
//   Flush                      kill the ID instruction
//   ForwardA, ForwardB         registered operand selects for the EX instruction
//   Stall                      combinational: hold PC and IF/ID this cycle
//   StallCount                 saturating stall-cycle counter
//   dbg_ex, dbg_mem, dbg_wb    tracking registers, exposed for observation
// ---------------------------------------------------------------------------
import pipe_pkg::*;

module forward_hazard_unit #(
  parameter int REG_ADDR_W = PIPE_REG_ADDR_W,
  parameter int CNT_W      = 16
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic                  ID_Valid,
  input  logic [REG_ADDR_W-1:0] ID_Rs,
  input  logic [REG_ADDR_W-1:0] ID_Rt,
  input  logic                  ID_UsesRt,
  input  logic [REG_ADDR_W-1:0] ID_Rd,
  input  logic                  ID_RegWrite,
  input  logic                  ID_MemRead,
  input  logic                  Flush,
  output logic [1:0]            ForwardA,
  output logic [1:0]            ForwardB,
  output logic                  Stall,
  output logic [CNT_W-1:0]      StallCount,
  output stage_track_t          dbg_ex,
  output stage_track_t          dbg_mem,
  output stage_track_t          dbg_wb
);

  stage_track_t ex_q, mem_q, wb_q;
  stage_track_t id_track;
  logic [1:0]   sel_a, sel_b;
  logic         load_use;
  logic         bubble;

  assign id_track = '{rd: ID_Rd, wr: ID_RegWrite, ld: ID_MemRead};

  fwd_select #(.ADDR_W(REG_ADDR_W)) u_sel_a (
    .en     (1'b1),
    .src    (ID_Rs),
    .ex_rd  (ex_q.rd),
    .ex_wr  (ex_q.wr),
    .mem_rd (mem_q.rd),
    .mem_wr (mem_q.wr),
    .fwd    (sel_a)
  );

  fwd_select #(.ADDR_W(REG_ADDR_W)) u_sel_b (
    .en     (ID_UsesRt),
    .src    (ID_Rt),
    .ex_rd  (ex_q.rd),
    .ex_wr  (ex_q.wr),
    .mem_rd (mem_q.rd),
    .mem_wr (mem_q.wr),
    .fwd    (sel_b)
  );

  // A load in EX has no result until the end of MEM, so a dependent ID
  // instruction waits one cycle and then picks the value up from MEM/WB.
  // Flush wins: a killed instruction never stalls.
  assign load_use = ex_q.ld && ex_q.wr && (ex_q.rd != '0) &&
                    ((ex_q.rd == ID_Rs) || (ID_UsesRt && (ex_q.rd == ID_Rt)));
  assign Stall    = ID_Valid && !Flush && load_use;
  assign bubble   = Stall || Flush || !ID_Valid;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      ex_q       <= STAGE_BUBBLE;
      mem_q      <= STAGE_BUBBLE;
      wb_q       <= STAGE_BUBBLE;
      ForwardA   <= FWD_REGFILE;
      ForwardB   <= FWD_REGFILE;
      StallCount <= '0;
    end else begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      if (bubble) begin
        ex_q     <= STAGE_BUBBLE;
        ForwardA <= FWD_REGFILE;
        ForwardB <= FWD_REGFILE;
      end else begin
        ex_q     <= id_track;
        ForwardA <= sel_a;
        ForwardB <= sel_b;
      end
      if (Stall && (StallCount != {CNT_W{1'b1}})) begin
        StallCount <= StallCount + 1'b1;
      end
    end
  end

  assign dbg_ex  = ex_q;
  assign dbg_mem = mem_q;
  assign dbg_wb  = wb_q;

endmodule
